urf_read_ctrl: RTL and testbench
================================

# urf_read_ctrl

Burst read controller for the universal register file (URF), the read-side counterpart to the URF write path. It accepts a burst read request (start address and length), issues single-cycle reads on the URF read port (one-cycle read latency), and returns the words on a valid/ready response stream. A small response buffer absorbs downstream backpressure without losing data.

## Interface
- DATA_WIDTH, 8, width of one URF word
- DEPTH, 16, number of URF entries; power of two
- ADDR_WIDTH, 4, log2(DEPTH)
- clk  in  1  free-running clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  burst request valid
- req_ready  out  1  controller can accept a request
- req_addr  in  ADDR_WIDTH  first address of burst
- req_len  in  ADDR_WIDTH  burst length minus one (0 → 1 word, DEPTH-1 → DEPTH words)
- rf_read_en  out  1  URF read strobe
- rf_read_addr  out  ADDR_WIDTH  URF read address
- rf_read_data  in  DATA_WIDTH  URF read data, valid the cycle after rf_read_en
- rsp_valid  out  1  response word valid
- rsp_ready  in  1  downstream accepts response word
- rsp_data  out  DATA_WIDTH  response word
- rsp_addr  out  ADDR_WIDTH  URF address the word was read from
- rsp_last  out  1  final word of the burst
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: req_ready=1. A request is accepted on an edge where req_valid and req_ready are both high. Address and length are latched, and the FSM moves to READ.
- READ: rf_read_en=1 with rf_read_addr=next address whenever the credit rule allows. When the final read is issued, the FSM moves to DRAIN.
- DRAIN: no reads are issued. Move to IDLE on the edge where the last word (rsp_last) completes its handshake.
- Address arithmetic: the next address is the previous one plus 1, modulo DEPTH, so DEPTH-1 wraps to 0. The issued-word counter runs to req_len inclusive.
- Response buffer: 3-entry FIFO.
  - It is written on the edge after an rf_read_en cycle with rf_read_data, the matching address, and a last flag.
  - It is popped on the rsp_valid & rsp_ready edge.
  - rsp_* outputs are driven from the FIFO head.
  - rsp_valid = FIFO not empty.
- Credit rule: issue a read only if (FIFO occupancy + reads in flight) < 3. This rule does not use rsp_ready combinationally. It guarantees no overflow and sustains one word per cycle when rsp_ready is held high.
- req_valid while not in IDLE is ignored: not accepted, with no side effects.
- busy=1 in READ and DRAIN.

## Timing
- Reset values: req_ready=1, rf_read_en=0, rf_read_addr=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0, busy=0. FIFO and counters are cleared.
- Reset mid-burst: on the next cycle all outputs are at reset values. Any in-flight rf_read_data is discarded and no stale word ever appears on rsp.
- Latency:
  - The request is accepted at edge E.
  - rf_read_en is high in the cycle after E (cycle C).
  - The first rsp_valid is high in cycle C+2.
- Throughput: with rsp_ready=1 continuously, an N-word burst has rf_read_en high for N consecutive cycles and rsp_valid high for N consecutive cycles.
- Backpressure:
  - While rsp_valid=1 and rsp_ready=0, rsp_data, rsp_addr and rsp_last stay stable.
  - At most 3 words are buffered, after which rf_read_en stays low until a pop frees a credit.
- Back-to-back bursts: req_ready returns to 1 in the cycle after the rsp_last handshake edge.
- Simultaneous FIFO push and pop on one edge: occupancy is unchanged and order is preserved.

## Test plan
- URF preloaded with mem[i]=i+0x10. Request addr=3, len=0, rsp_ready=1 → exactly one rf_read_en (addr 3). Then rsp_data=0x13, rsp_addr=3, rsp_last=1, with rsp_valid 2 cycles after rf_read_en. busy returns to 0.
- Request addr=14, len=3, rsp_ready=1 → reads at 14, 15, 0, 1 on consecutive cycles. rsp_data=0x1E, 0x1F, 0x10, 0x11 on consecutive cycles, with rsp_last only on 0x11.
- Request addr=0, len=15, rsp_ready=0 for 10 cycles then 1 → exactly 3 rf_read_en pulses, then a stall. rsp_data holds 0x10 while stalled. All 16 words arrive in order with no loss or duplication.
- rsp_ready toggling pseudo-randomly during a len=15 burst → the scoreboard matches 16 words in order. FIFO occupancy never exceeds 3, and rsp fields are stable whenever valid & !ready.
- Second request held on req_valid during a len=7 burst → it is not accepted until the cycle after the rsp_last handshake. It is then served correctly, with no overlap.
- rst asserted for one cycle after the 2nd response word of a len=7 burst → the next cycle shows rsp_valid=0, busy=0, req_ready=1 and rf_read_en=0. A new request addr=5, len=1 then returns 0x15, 0x16 with no stale data.

Source files
------------

// File: rtl/urf_read_ctrl.sv
// ---------------------------------------------------------------------------
// urf_read_ctrl
//   Burst read controller for the universal register file (URF). A burst
//   request (start address + length-minus-one) is turned into a stream of
//   single-cycle URF reads. The returned words are delivered on a
//   valid/ready response stream through a 3-entry buffer. Reads are issued
//   against a credit count so that the buffer can never overflow.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : burst request valid (accepted only in IDLE)
//   req_ready     : controller idle and able to accept a request
//   req_addr      : first URF address of the burst
//   req_len       : burst length minus one
//   rf_read_en    : URF read strobe
//   rf_read_addr  : URF read address (0 when no read is issued)
//   rf_read_data  : URF read data, valid one cycle after rf_read_en
//   rsp_valid     : response word available at buffer head
//   rsp_ready     : downstream accepts the response word
//   rsp_data      : response word
//   rsp_addr      : URF address the response word came from
//   rsp_last      : response word is the final word of the burst
//   busy          : controller is in READ or DRAIN
// ---------------------------------------------------------------------------
module urf_read_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ADDR_WIDTH-1:0] req_len,
    output logic                  rf_read_en,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  rsp_last,
    output logic                  busy
);

    localparam int FIFO_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Burst bookkeeping
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [ADDR_WIDTH-1:0] burst_len;
    logic                  credit_ok;
    logic                  issue;
    logic                  issue_last;
    logic                  accept;

    // Read-return pipeline (one-cycle URF latency)
    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic                  last_p1;

    // Response buffer
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            fifo_cnt;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    // Address successor: wraps DEPTH-1 back to 0.
    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return ADDR_WIDTH'((32'(a) + 32'd1) % DEPTH);
    endfunction

    // Buffer pointer successor over FIFO_DEPTH entries (not a power of two).
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Every issued read owns a buffer slot from the moment it is issued until
    // its word is popped, so buffered words plus the one read in flight must
    // leave room for another. This never looks at rsp_ready.
    assign credit_ok  = ({1'b0, fifo_cnt} + {2'b00, vld_p1}) < 3'(FIFO_DEPTH);
    assign issue      = (state == READ) && credit_ok;
    assign issue_last = issue && (rd_cnt == burst_len);
    assign accept     = (state == IDLE) && req_valid;

    assign fifo_empty = (fifo_cnt == 2'd0);
    assign push       = vld_p1;
    assign pop        = !fifo_empty && rsp_ready;

    // FSM next state and control outputs
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = READ;
            end
            READ: begin
                if (issue_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && fifo_last[rd_ptr]) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rf_read_en   = issue;
    assign rf_read_addr = issue ? rd_addr : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr   <= '0;
            rd_cnt    <= '0;
            burst_len <= '0;
        end else if (accept) begin
            rd_addr   <= req_addr;
            rd_cnt    <= '0;
            burst_len <= req_len;
        end else if (issue) begin
            rd_addr   <= addr_inc(rd_addr);
            rd_cnt    <= rd_cnt + ADDR_WIDTH'(1);
        end
    end

    // ---- stage p0 -> p1: read issued, URF data arrives next cycle ----
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= issue;
    end

    always_ff @(posedge clk) begin
        addr_p1 <= rd_addr;
        last_p1 <= issue_last;
    end

    // ---- stage p1 -> buffer: capture URF data with its address/last ----
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= rf_read_data;
            fifo_addr[wr_ptr] <= addr_p1;
            fifo_last[wr_ptr] <= last_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Head fields are masked while empty so stale or never-written entries
    // are never visible and the outputs read 0 out of reset.
    assign rsp_valid = !fifo_empty;
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_addr  = rsp_valid ? fifo_addr[rd_ptr] : '0;
    assign rsp_last  = rsp_valid && fifo_last[rd_ptr];

endmodule

// File: tb/tb_urf_read_ctrl.sv
// ---------------------------------------------------------------------------
// tb_urf_read_ctrl
//   Directed bench for urf_read_ctrl. A behavioural URF (mem[i] = i + 0x10,
//   one-cycle read latency) answers the controller; a negedge monitor logs
//   reads, request acceptances and response handshakes, and checks response
//   stability under backpressure and the outstanding-word bound.
// ---------------------------------------------------------------------------
module tb_urf_read_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_len;
    logic          rf_read_en;
    logic [AW-1:0] rf_read_addr;
    logic [DW-1:0] rf_read_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          rsp_last;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    urf_read_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .rf_read_en(rf_read_en), .rf_read_addr(rf_read_addr),
        .rf_read_data(rf_read_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_last(rsp_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // URF model
    logic [DW-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 'h10);
    always @(posedge clk) if (rf_read_en) rf_read_data <= mem[rf_read_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor
    int cyc = 0;
    int rd_addr_q[$], rd_cyc_q[$], acc_q[$];
    int rs_data_q[$], rs_addr_q[$], rs_last_q[$], rs_cyc_q[$];
    int outstanding = 0;
    logic hold = 1'b0;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_addr;
    logic          hold_last;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            outstanding = 0;
            hold        = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_data", rsp_data, hold_data);
                chk("hold_addr", rsp_addr, hold_addr);
                chk("hold_last", rsp_last, hold_last);
            end
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (rf_read_en) begin
                rd_addr_q.push_back(rf_read_addr);
                rd_cyc_q.push_back(cyc);
                outstanding++;
                chk("outstanding_le3", outstanding <= 3, 1);
            end
            if (rsp_valid && rsp_ready) begin
                rs_data_q.push_back(rsp_data);
                rs_addr_q.push_back(rsp_addr);
                rs_last_q.push_back(rsp_last);
                rs_cyc_q.push_back(cyc);
                outstanding--;
            end
            hold      = rsp_valid && !rsp_ready;
            hold_data = rsp_data;
            hold_addr = rsp_addr;
            hold_last = rsp_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_addr_q.delete(); rd_cyc_q.delete(); acc_q.delete();
        rs_data_q.delete(); rs_addr_q.delete(); rs_last_q.delete(); rs_cyc_q.delete();
    endtask

    // Returns #1 after the acceptance edge (i.e. in the first READ cycle).
    task automatic send_req(input int a, input int l);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = AW'(a);
        req_len   = AW'(l);
        while (!req_ready && n < 200) begin tick(); n++; end
        chk("req_accept_timeout", n < 200, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin tick(); n++; end
        chk("idle_timeout", busy, 0);
    endtask

    // Checks the response log against a burst from 'a' of 'cnt' words,
    // starting at log index 'base'; last expected only on the final word.
    task automatic chk_burst(input string tag, input int base, input int a, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int ad;
            ad = (a + i) % DEPTH;
            if (base + i < rs_data_q.size()) begin
                chk({tag, "_data"}, rs_data_q[base+i], ad + 'h10);
                chk({tag, "_addr"}, rs_addr_q[base+i], ad);
                chk({tag, "_last"}, rs_last_q[base+i], (i == cnt - 1) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rf_read_en", rf_read_en, 0);
        chk("rst_rf_read_addr", rf_read_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Single-word burst, latency
        clear_logs();
        rsp_ready = 1'b1;
        send_req(3, 0);
        chk("t1_rd_en_after_accept", rf_read_en, 1);
        chk("t1_rd_addr_after_accept", rf_read_addr, 3);
        chk("t1_busy", busy, 1);
        wait_idle(50);
        tick(); tick();
        chk("t1_rd_count", rd_addr_q.size(), 1);
        chk("t1_rsp_count", rs_data_q.size(), 1);
        if (rd_addr_q.size() == 1 && rs_data_q.size() == 1) begin
            chk("t1_rd_addr", rd_addr_q[0], 3);
            chk("t1_latency", rs_cyc_q[0] - rd_cyc_q[0], 2);
        end
        chk_burst("t1", 0, 3, 1);
        chk("t1_req_ready_idle", req_ready, 1);

        // Wrapping 4-word burst at full rate
        clear_logs();
        send_req(14, 3);
        wait_idle(50);
        tick();
        chk("t2_rd_count", rd_addr_q.size(), 4);
        chk("t2_rsp_count", rs_data_q.size(), 4);
        if (rd_addr_q.size() == 4 && rs_data_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_rd_addr", rd_addr_q[i], (14 + i) % DEPTH);
                chk("t2_rd_consec", rd_cyc_q[i] - rd_cyc_q[0], i);
                chk("t2_rsp_consec", rs_cyc_q[i] - rs_cyc_q[0], i);
            end
        end
        chk_burst("t2", 0, 14, 4);

        // Full burst stalled by backpressure, then released
        clear_logs();
        rsp_ready = 1'b0;
        send_req(0, 15);
        for (int i = 0; i < 10; i++) tick();
        chk("t3_stall_rd_count", rd_addr_q.size(), 3);
        chk("t3_stall_rf_read_en", rf_read_en, 0);
        chk("t3_stall_rsp_valid", rsp_valid, 1);
        chk("t3_stall_rsp_data", rsp_data, 'h10);
        chk("t3_stall_no_pop", rs_data_q.size(), 0);
        rsp_ready = 1'b1;
        wait_idle(100);
        tick();
        chk("t3_rd_count", rd_addr_q.size(), 16);
        chk("t3_rsp_count", rs_data_q.size(), 16);
        chk_burst("t3", 0, 0, 16);

        // Pseudo-random backpressure over a full burst
        clear_logs();
        send_req(0, 15);
        n = 0;
        while (busy && n < 600) begin
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("t4_idle_timeout", busy, 0);
        rsp_ready = 1'b1;
        tick();
        chk("t4_rsp_count", rs_data_q.size(), 16);
        chk_burst("t4", 0, 0, 16);

        // Second request held during a burst
        clear_logs();
        send_req(8, 7);
        acc_q.delete();
        req_valid = 1'b1; req_addr = 4'd2; req_len = 4'd1;
        tick();
        chk("t5_req_ready_busy", req_ready, 0);
        n = 0;
        while (acc_q.size() == 0 && n < 100) begin tick(); n++; end
        req_valid = 1'b0;
        chk("t5_accept_timeout", n < 100, 1);
        chk("t5_rsp_before_accept", rs_data_q.size(), 8);
        if (acc_q.size() == 1 && rs_cyc_q.size() >= 8)
            chk("t5_accept_after_last", acc_q[0] - rs_cyc_q[7], 1);
        wait_idle(50);
        tick();
        chk("t5_accept_count", acc_q.size(), 1);
        chk("t5_rsp_count", rs_data_q.size(), 10);
        chk_burst("t5a", 0, 8, 8);
        chk_burst("t5b", 8, 2, 2);

        // Reset mid-burst
        clear_logs();
        send_req(0, 7);
        n = 0;
        while (rs_data_q.size() < 2 && n < 50) begin tick(); n++; end
        chk("t6_two_words_timeout", rs_data_q.size(), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_req_ready", req_ready, 1);
        chk("t6_rf_read_en", rf_read_en, 0);
        clear_logs();
        tick(); tick(); tick();
        chk("t6_no_stale", rs_data_q.size(), 0);
        send_req(5, 1);
        wait_idle(50);
        tick(); tick();
        chk("t6_rsp_count", rs_data_q.size(), 2);
        chk_burst("t6", 0, 5, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
